// File: rtl/spi_ahb_loader.sv
// spi_ahb_loader: SPI-slave (mode 0) to AHB-Lite master bridge, one single-word transfer per frame.
// Latency: NONSEQ is driven 4 clk after the sclk rise carrying the last address (read) or data (write) bit.
// Backpressure: spi_hready=0 stretches the AHB address/data phase; a read data phase that runs past the dummy byte returns all-ones and sets err.
// Ports: clk/rst; SPI pins sclk, cs_n, mosi, miso; AHB master spi_h* (hrest = HRESP); busy = frame or AHB transfer active.
module spi_ahb_loader #(
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso,
   output logic [31:0] spi_haddr,
   output logic        spi_hwrite,
   output logic [2:0]  spi_hsize,
   output logic [2:0]  spi_hburst,
   output logic        spi_hmastlock,
   output logic [3:0]  spi_hprot,
   output logic [1:0]  spi_htrans,
   output logic [31:0] spi_hwdata,
   input  logic        spi_hready,
   input  logic        spi_hrest,
   input  logic [31:0] spi_hrdata,
   output logic        busy
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_ADDR, S_WDATA, S_AHB_A, S_AHB_D,
      S_DUMMY, S_RDATA, S_STAT_OUT, S_DRAIN
   } state_t;

   state_t      state;
   logic [1:0]  sclk_s, cs_s, mosi_s;
   logic        sclk_d, cs_d;
   logic        sclk_rise, sclk_fall;
   logic [6:0]  bit_cnt;
   logic [31:0] in_sh, out_sh;
   logic        is_write, err, late;
   logic [31:0] in_next;
   logic        cs_fall, cs_rise, late_now;

   assign spi_hsize     = 3'b010;
   assign spi_hburst    = 3'b000;
   assign spi_hmastlock = 1'b0;
   assign spi_hprot     = HPROT_VAL;

   assign in_next = {in_sh[30:0], mosi_s[1]};
   assign cs_fall = cs_d & ~cs_s[1];
   assign cs_rise = ~cs_d & cs_s[1];
   // First read-data bit is due (fall after the 48th rise) but the AHB read is still in flight.
   assign late_now = sclk_fall && (bit_cnt == 7'd48) && !is_write && !late;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_s     <= 2'b00;
         cs_s       <= 2'b11;
         mosi_s     <= 2'b00;
         sclk_d     <= 1'b0;
         cs_d       <= 1'b1;
         sclk_rise  <= 1'b0;
         sclk_fall  <= 1'b0;
         state      <= S_IDLE;
         bit_cnt    <= '0;
         in_sh      <= '0;
         out_sh     <= '0;
         is_write   <= 1'b0;
         err        <= 1'b0;
         late       <= 1'b0;
         miso       <= 1'b0;
         busy       <= 1'b0;
         spi_haddr  <= '0;
         spi_hwrite <= 1'b0;
         spi_htrans <= HTRANS_IDLE;
         spi_hwdata <= '0;
      end else begin
         sclk_s    <= {sclk_s[0], sclk};
         cs_s      <= {cs_s[0], cs_n};
         mosi_s    <= {mosi_s[0], mosi};
         sclk_d    <= sclk_s[1];
         cs_d      <= cs_s[1];
         // Edge pulses are registered so mosi_s[1] has settled for the sample.
         sclk_rise <= sclk_s[1] & ~sclk_d;
         sclk_fall <= ~sclk_s[1] & sclk_d;

         if (sclk_rise) in_sh <= in_next;

         if (cs_fall) bit_cnt <= '0;
         else if (sclk_rise && !cs_s[1]) bit_cnt <= bit_cnt + 7'd1;

         // Output shifter: status byte, read word, or the all-ones late substitute.
         if (sclk_fall && (state == S_RDATA || state == S_STAT_OUT || late)) begin
            miso   <= out_sh[31];
            out_sh <= {out_sh[30:0], 1'b0};
         end

         case (state)
            S_IDLE: if (cs_fall) begin
               state <= S_CMD;
               busy  <= 1'b1;
            end
            S_CMD: if (sclk_rise && bit_cnt == 7'd7) begin
               case (in_next[7:0])
                  8'h02, 8'h03: begin
                     is_write <= (in_next[7:0] == 8'h02);
                     state    <= S_ADDR;
                  end
                  8'h05: begin
                     // Low bit reports an in-flight AHB transfer; a frame only starts from idle, so it reads 0.
                     out_sh <= {6'b0, err, 1'b0, 24'h0};
                     state  <= S_STAT_OUT;
                  end
                  default: state <= S_DRAIN;
               endcase
            end
            S_ADDR: if (sclk_rise && bit_cnt == 7'd39) begin
               spi_haddr <= {in_next[31:2], 2'b00};
               if (is_write) begin
                  state <= S_WDATA;
               end else begin
                  spi_hwrite <= 1'b0;
                  spi_htrans <= HTRANS_NONSEQ;
                  late       <= 1'b0;
                  state      <= S_AHB_A;
               end
            end
            S_WDATA: if (sclk_rise && bit_cnt == 7'd71) begin
               spi_hwdata <= in_next;
               spi_hwrite <= 1'b1;
               spi_htrans <= HTRANS_NONSEQ;
               late       <= 1'b0;
               state      <= S_AHB_A;
            end
            S_AHB_A: begin
               if (late_now) begin
                  late   <= 1'b1;
                  err    <= 1'b1;
                  miso   <= 1'b1;
                  out_sh <= 32'hFFFF_FFFE;
               end
               if (spi_hready) begin
                  spi_htrans <= HTRANS_IDLE;
                  state      <= S_AHB_D;
               end
            end
            S_AHB_D: begin
               if (late_now) begin
                  late   <= 1'b1;
                  err    <= 1'b1;
                  miso   <= 1'b1;
                  out_sh <= 32'hFFFF_FFFE;
               end
               if (spi_hready) begin
                  if (spi_hrest) err <= 1'b1;
                  if (cs_s[1]) begin
                     // Host already ended the frame; the transfer has now drained.
                     state <= S_IDLE;
                     busy  <= 1'b0;
                     late  <= 1'b0;
                     miso  <= 1'b0;
                  end else if (is_write) begin
                     state <= S_DRAIN;
                  end else if (late || late_now) begin
                     state <= S_RDATA;
                  end else begin
                     out_sh <= spi_hrest ? '0 : spi_hrdata;
                     state  <= S_DUMMY;
                  end
               end
            end
            S_DUMMY: if (sclk_fall && bit_cnt == 7'd48) begin
               miso   <= out_sh[31];
               out_sh <= {out_sh[30:0], 1'b0};
               state  <= S_RDATA;
            end
            S_RDATA, S_STAT_OUT, S_DRAIN: ;
            default: state <= S_IDLE;
         endcase

         // CS rise ends the frame everywhere except mid-AHB, which must complete first.
         if (cs_rise && state != S_IDLE && state != S_AHB_A && state != S_AHB_D) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            late  <= 1'b0;
            miso  <= 1'b0;
            if (state == S_STAT_OUT) err <= 1'b0;
         end
      end
   end

endmodule
